// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg
// Shared types and helpers for the AXI-Stream upsizer.
//   - up_state_e      : collect/hold state of the output register
//   - lane_idx_w()    : width of a lane index for a given lane count
//   - keep_contiguous : true when a keep vector is non-empty and packed from bit 0
// -----------------------------------------------------------------------------
package axis_pkg;

    // Widest keep vector the contiguity helper handles; callers zero-extend.
    localparam int unsigned MaxLanes = 64;

    typedef enum logic [0:0] {
        StCollect,
        StHold
    } up_state_e;

    // A lane counter always gets at least one bit, even for degenerate counts.
    function automatic int unsigned lane_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // keep must have bit 0 set and be of the form 0..01..1.
    // Adding one to a run of low ones clears it, so the AND is zero only then.
    function automatic logic keep_contiguous(input logic [MaxLanes-1:0] keep);
        logic [MaxLanes-1:0] plus_one;
        plus_one = keep + MaxLanes'(1);
        return keep[0] && ((keep & plus_one) == '0);
    endfunction

endpackage

// File: rtl/axis_upsizer_n_if.sv
// -----------------------------------------------------------------------------
// axis_upsizer_n_if
// AXI-Stream bundle used on both sides of the upsizer.
//   DW     : tdata width
//   KW     : tkeep width (one bit per lane)
//   tdata, tkeep, tlast, tvalid : driven by the master
//   tready                      : driven by the slave
// -----------------------------------------------------------------------------
interface axis_upsizer_n_if #(
    parameter int unsigned DW = 40,
    parameter int unsigned KW = 1
);

    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic          tlast;
    logic          tvalid;
    logic          tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/axis_upsizer_n.sv
// -----------------------------------------------------------------------------
// axis_upsizer_n
// Packs N consecutive W-bit AXI-Stream beats into one N*W-bit word. The first
// beat of a word lands in lane 0 (LSBs). A beat with tlast closes the word
// early; unused upper lanes are zero with keep cleared.
//
// Ports
//   aclk     : clock, rising edge
//   aresetn  : asynchronous active-low reset
//   in_if    : narrow slave side (tdata W bits; tkeep is ignored)
//   out_if   : wide master side (tdata N*W bits, tkeep N bits)
//
// The output register doubles as the packing buffer: while out_tvalid is low
// the lanes fill in place; once a word is complete it is held until taken.
// in_tready = ~out_tvalid | out_tready, so a drain and the first beat of the
// next word share a cycle and one beat per cycle is sustained.
// -----------------------------------------------------------------------------
module axis_upsizer_n
    import axis_pkg::*;
#(
    parameter int unsigned W = 40,
    parameter int unsigned N = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    axis_upsizer_n_if.slave  in_if,
    axis_upsizer_n_if.master out_if
);

    localparam int unsigned     LaneW    = lane_idx_w(N);
    localparam logic [LaneW-1:0] LastLane = LaneW'(N - 1);

    up_state_e state_q, state_d;

    logic [LaneW-1:0]      lane_q, lane_d;
    logic [N-1:0][W-1:0]   data_q, data_d;
    logic [N-1:0]          keep_q, keep_d;
    logic                  last_q, last_d;

    logic                  in_ready;
    logic                  out_valid;
    logic                  accept;
    logic                  word_start;
    logic                  word_done;
    logic [N-1:0]          lane_we;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    assign accept     = in_if.tvalid & in_ready;
    assign word_start = accept & (lane_q == '0);
    assign word_done  = accept & (in_if.tlast | (lane_q == LastLane));

    for (genvar k = 0; k < N; k++) begin : g_lane_we
        assign lane_we[k] = accept & (lane_q == LaneW'(k));
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StCollect;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StCollect: begin
                if (word_done) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                // A drain may coincide with a beat that completes the next
                // word on its own (tlast in lane 0); then stay holding.
                if (out_if.tready) begin
                    state_d = word_done ? StHold : StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        unique case (state_q)
            StCollect: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
            StHold: begin
                in_ready  = out_if.tready;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Lane datapath next state
    // -------------------------------------------------------------------------
    always_comb begin
        data_d = data_q;
        keep_d = keep_q;
        for (int k = 0; k < N; k++) begin
            if (lane_we[k]) begin
                data_d[k] = in_if.tdata;
                keep_d[k] = 1'b1;
            end else if (word_start) begin
                // Opening a new word wipes whatever the previous word left.
                data_d[k] = '0;
                keep_d[k] = 1'b0;
            end
        end
    end

    always_comb begin
        lane_d = lane_q;
        if (accept) begin
            lane_d = word_done ? '0 : lane_q + LaneW'(1);
        end
    end

    always_comb begin
        last_d = last_q;
        if (word_done) begin
            last_d = in_if.tlast;
        end else if (word_start) begin
            last_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lane_q <= '0;
            data_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
        end else begin
            lane_q <= lane_d;
            data_q <= data_d;
            keep_q <= keep_d;
            last_q <= last_d;
        end
    end

    // -------------------------------------------------------------------------
    // Port drive
    // -------------------------------------------------------------------------
    assign in_if.tready  = in_ready;
    assign out_if.tvalid = out_valid;
    assign out_if.tdata  = data_q;
    assign out_if.tkeep  = keep_q;
    assign out_if.tlast  = last_q;

    // -------------------------------------------------------------------------
    // Properties
    // -------------------------------------------------------------------------
    a_hold_stable: assert property (
        @(posedge aclk) disable iff (!aresetn)
        (out_valid && !out_if.tready) |=>
            (out_valid && $stable(data_q) && $stable(keep_q) && $stable(last_q))
    );

    a_keep_contig: assert property (
        @(posedge aclk) disable iff (!aresetn)
        out_valid |-> keep_contiguous(MaxLanes'(keep_q))
    );

    a_lane_range: assert property (
        @(posedge aclk) disable iff (!aresetn)
        lane_q <= LastLane
    );

endmodule

// File: doc/axis_upsizer_n.md
# axis_upsizer_n

Parametrised AXI-Stream width upsizer: packs N consecutive W-bit input beats into one N*W-bit output word, with per-lane keep and packet-boundary (tlast) support so short packets flush a partial word. Sits between a narrow producer and a wide consumer in the stream datapath. It generalises the fixed 2:1 upsizer and sustains one input beat per cycle under continuous downstream readiness.

## Interface
- W, 40, input lane width in bits (>= 1)
- N, 4, upsizing ratio / lanes per output word (>= 2)
- aclk  input  1  clock, all logic on rising edge
- aresetn  input  1  reset, asynchronous, active-low
- in_tdata  input  W  input beat
- in_tlast  input  1  last beat of packet
- in_tvalid  input  1  input valid
- in_tready  output  1  input ready
- out_tdata  output  N*W  packed word; lane k = bits [k*W +: W]
- out_tkeep  output  N  lane k holds valid data
- out_tlast  output  1  word ends a packet
- out_tvalid  output  1  output valid
- out_tready  input  1  output ready

## Operation
- State: lane counter lane (0..N-1, width $clog2(N)) plus out_tvalid; collecting when out_tvalid=0, holding when out_tvalid=1.
- Accept = in_tvalid & in_tready. in_tready = ~out_tvalid | out_tready (combinational).
- Lane order: first accepted beat of a word goes to lane 0 (LSBs), next to lane 1, etc.
- Accept with lane=0: lane 0 := in_tdata, lanes 1..N-1 := 0, out_tkeep := 1, out_tlast := 0.
- Accept with lane=k>0: lane k := in_tdata, out_tkeep[k] := 1; other lanes unchanged.
- Word completes on accept when lane=N-1 or in_tlast=1: out_tvalid := 1, out_tlast := in_tlast, lane := 0. Otherwise lane := lane+1.
- Partial word (tlast at lane k<N-1): out_tkeep = lanes 0..k set, remaining lanes zero data, keep 0.
- Hold: out_tvalid=1 & out_tready=0 -> all out_* stable, in_tready=0, no accept.
- Drain: out_tvalid=1 & out_tready=1 -> in_tready=1; if accept in same cycle it starts the next word at lane 0 (overwrite rules above); out_tvalid stays 1 only if that beat also completes the word (N=... only tlast at lane 0), else out_tvalid := 0.
- Collecting with out_tready irrelevant: out_tvalid=0 never blocks input.
- out_tkeep is always contiguous from bit 0.

## Timing
- Reset: out_tdata=0, out_tkeep=0, out_tlast=0, out_tvalid=0, lane=0; in_tready=1 after reset.
- Latency: out_tvalid rises the cycle after the completing beat is accepted.
- Throughput: 1 input beat/cycle sustained with out_tready=1; no bubble between output words.
- Reset mid-word: partial word discarded, no output emitted, lane=0.
- tlast on lane 0 with N beats pending nothing: yields keep=...0001, out_tlast=1.
- Assertions: out_tvalid & ~out_tready -> out_* stable next cycle; out_tvalid -> out_tkeep[0]=1 and keep contiguous; lane < N.

## Structure
- Package axis_pkg: lane-index width helper function, keep-contiguity check function shared by assertions and bench.
- Single module, no sub-module; lane counter and per-lane write enables are local logic (generate loop over N lanes).

## Test plan
- W=8,N=4, out_tready=1, stream 0x11,0x22,0x33,0x44 -> one word 0x44332211, keep=1111, tlast=0, valid cycle after 4th accept.
- Beats 0xA1,0xA2 with tlast on 0xA2 -> word 0x0000A2A1, keep=0011, tlast=1; next beat lands in lane 0.
- 8 back-to-back beats, out_tready=1 -> two words, in_tready never low, no gap.
- Complete word then out_tready=0 for 3 cycles -> in_tready=0, outputs frozen; release -> word drains, next beat accepted same cycle.
- aresetn low after 2 beats of a word -> all outputs 0, then 4 fresh beats produce only the fresh word.
- N=2,W=40 single-beat tlast packet 0x12_3456_789A -> keep=01, upper lane 0, tlast=1.
